// File: rtl/hdb3_pkg.sv
// Shared HDB3 line-code definitions for the encoder and decoder sides.
package hdb3_pkg;

   localparam int unsigned CODE_W = 2;
   localparam int unsigned ZCNT_W = 2;

   typedef logic [CODE_W-1:0] hdb3_code_t;

   localparam hdb3_code_t HDB3_ZERO = 2'b00;
   localparam hdb3_code_t HDB3_ONE  = 2'b01;
   localparam hdb3_code_t HDB3_B    = 2'b10;
   localparam hdb3_code_t HDB3_V    = 2'b11;

   // Zero count at which the next zero completes a run of four.
   localparam logic [ZCNT_W-1:0] ZCNT_LAST = ZCNT_W'(3);

   // Registered output symbol bundle.
   typedef struct packed {
      hdb3_code_t code;
      hdb3_code_t dec;
      logic       b_flag;
      logic       pos;
      logic       neg;
   } hdb3_sym_t;

   // Marked code to decoder code: B folds into a plain mark.
   function automatic hdb3_code_t hdb3_dec_map(input hdb3_code_t c);
      return {c == HDB3_V, c != HDB3_ZERO};
   endfunction

endpackage

// File: rtl/hdb3_enc_ctrl_if.sv
// Bit-strobe input and symbol/line outputs of the HDB3 encoder.
interface hdb3_enc_ctrl_if;
   import hdb3_pkg::*;

   logic       en;
   logic       din;
   hdb3_code_t code_out;
   hdb3_code_t dec_code;
   logic       b_flag;
   logic       pos;
   logic       neg;

   modport master (
      output en, din,
      input  code_out, dec_code, b_flag, pos, neg
   );

   modport slave (
      input  en, din,
      output code_out, dec_code, b_flag, pos, neg
   );

endinterface

// File: rtl/hdb3_pol_sched.sv
// HDB3 polarity scheduler: assigns +/- to each mark and registers outputs.
module hdb3_pol_sched
   import hdb3_pkg::*;
#(
   parameter logic INIT_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  hdb3_code_t s3_i,
   output hdb3_code_t code_o,
   output hdb3_code_t dec_o,
   output logic       b_flag_o,
   output logic       pos_o,
   output logic       neg_o
);

   logic      last_pol_q, last_pol_d;
   hdb3_sym_t sym_q, sym_d;

   // Next symbol: marks and B alternate polarity, V repeats the last one.
   always_comb begin
      last_pol_d = last_pol_q;
      sym_d      = sym_q;
      if (en_i) begin
         sym_d.code   = s3_i;
         sym_d.dec    = hdb3_dec_map(s3_i);
         sym_d.b_flag = (s3_i == HDB3_B);
         case (s3_i)
            HDB3_ONE, HDB3_B: begin
               last_pol_d = ~last_pol_q;
               sym_d.pos  = ~last_pol_q;
               sym_d.neg  = last_pol_q;
            end
            HDB3_V: begin
               sym_d.pos = last_pol_q;
               sym_d.neg = ~last_pol_q;
            end
            default: begin
               sym_d.pos = 1'b0;
               sym_d.neg = 1'b0;
            end
         endcase
      end
   end

   // Polarity and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_pol_q <= INIT_POL;
         sym_q      <= '0;
      end else begin
         last_pol_q <= last_pol_d;
         sym_q      <= sym_d;
      end
   end

   assign code_o   = sym_q.code;
   assign dec_o    = sym_q.dec;
   assign b_flag_o = sym_q.b_flag;
   assign pos_o    = sym_q.pos;
   assign neg_o    = sym_q.neg;

endmodule

// File: rtl/hdb3_enc_ctrl.sv
// HDB3 encoder: 4-deep look-ahead pipeline choosing 000V / B00V substitution.
module hdb3_enc_ctrl
   import hdb3_pkg::*;
#(
   parameter logic INIT_POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   hdb3_enc_ctrl_if.slave bus
);

   hdb3_code_t        s0_q, s0_d;
   hdb3_code_t        s1_q, s1_d;
   hdb3_code_t        s2_q, s2_d;
   hdb3_code_t        s3_q, s3_d;
   logic [ZCNT_W-1:0] zero_cnt_q, zero_cnt_d;
   logic              par_q, par_d;

   hdb3_code_t code_w;
   hdb3_code_t dec_w;
   logic       b_flag_w;
   logic       pos_w;
   logic       neg_w;

   // Shift the pipeline; the fourth zero becomes V and may retro-mark the run's first zero as B.
   always_comb begin
      s0_d       = s0_q;
      s1_d       = s1_q;
      s2_d       = s2_q;
      s3_d       = s3_q;
      zero_cnt_d = zero_cnt_q;
      par_d      = par_q;
      if (bus.en) begin
         s1_d = s0_q;
         s2_d = s1_q;
         s3_d = s2_q;
         if (bus.din) begin
            s0_d       = HDB3_ONE;
            zero_cnt_d = '0;
            par_d      = ~par_q;
         end else if (zero_cnt_q == ZCNT_LAST) begin
            s0_d       = HDB3_V;
            zero_cnt_d = '0;
            par_d      = 1'b0;
            if (!par_q) begin
               s3_d = HDB3_B;
            end
         end else begin
            s0_d       = HDB3_ZERO;
            zero_cnt_d = zero_cnt_q + ZCNT_W'(1);
         end
      end
   end

   // Pipeline, run counter and mark parity registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q       <= HDB3_ZERO;
         s1_q       <= HDB3_ZERO;
         s2_q       <= HDB3_ZERO;
         s3_q       <= HDB3_ZERO;
         zero_cnt_q <= '0;
         par_q      <= 1'b0;
      end else begin
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         zero_cnt_q <= zero_cnt_d;
         par_q      <= par_d;
      end
   end

   hdb3_pol_sched #(
      .INIT_POL (INIT_POL)
   ) u_pol_sched (
      .clk      (clk),
      .rst      (rst),
      .en_i     (bus.en),
      .s3_i     (s3_q),
      .code_o   (code_w),
      .dec_o    (dec_w),
      .b_flag_o (b_flag_w),
      .pos_o    (pos_w),
      .neg_o    (neg_w)
   );

   assign bus.code_out = code_w;
   assign bus.dec_code = dec_w;
   assign bus.b_flag   = b_flag_w;
   assign bus.pos      = pos_w;
   assign bus.neg      = neg_w;

endmodule

// File: tb/tb_hdb3_enc_ctrl.sv
// Self-checking bench for hdb3_enc_ctrl: directed tables, gap/reset sequences, random stream.
module tb_hdb3_enc_ctrl;

   localparam int N  = 10000;
   localparam int NT = N + 4;

   typedef struct {
      bit       rst_before;
      bit       din;
      bit [1:0] code;
      bit       pos;
      bit       neg;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   rnd_prints;

   vec_t tbl[$];

   bit       rin[NT];
   bit [1:0] msym[NT];
   bit       mpos[NT];
   bit       mneg[NT];
   bit       lpulse[N];
   bit       lpol[N];
   bit [1:0] ocode[N];

   bit [1:0] e1c[12];
   bit       e1p[12];
   bit       e1n[12];

   hdb3_enc_ctrl_if ifc ();

   hdb3_enc_ctrl #(
      .INIT_POL (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_out(input string nm, input bit [1:0] code, input bit p, input bit n);
      bit [1:0] dec;
      dec = {code == 2'b11, code != 2'b00};
      chk({nm, "_code"}, 32'(ifc.code_out), 32'(code));
      chk({nm, "_dec"}, 32'(ifc.dec_code), 32'(dec));
      chk({nm, "_bflag"}, 32'(ifc.b_flag), 32'(code == 2'b10));
      chk({nm, "_pos"}, 32'(ifc.pos), 32'(p));
      chk({nm, "_neg"}, 32'(ifc.neg), 32'(n));
   endtask

   task automatic cyc(input bit e, input bit d);
      @(negedge clk);
      ifc.en  = e;
      ifc.din = d;
      @(posedge clk);
      #1;
   endtask

   // Reset is held with en=1, din=1 to show it wins over the strobe.
   task automatic do_reset(input string nm);
      @(negedge clk);
      rst     = 1'b1;
      ifc.en  = 1'b1;
      ifc.din = 1'b1;
      @(posedge clk);
      #1;
      check_out(nm, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      ifc.en = 1'b0;
   endtask

   function automatic void add_vec(input bit r, input bit d, input bit [1:0] c, input bit p, input bit n);
      vec_t v;
      v.rst_before = r;
      v.din        = d;
      v.code       = c;
      v.pos        = p;
      v.neg        = n;
      tbl.push_back(v);
   endfunction

   // Reference: substitute every 4-zero run by whole-stream scan, then assign polarity.
   function automatic void build_model();
      int zc;
      bit par;
      bit lp;
      zc  = 0;
      par = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (rin[i]) begin
            msym[i] = 2'b01;
            zc      = 0;
            par     = ~par;
         end else if (zc == 3) begin
            msym[i] = 2'b11;
            if (!par) msym[i-3] = 2'b10;
            par = 1'b0;
            zc  = 0;
         end else begin
            msym[i] = 2'b00;
            zc++;
         end
      end
      lp = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (msym[i] == 2'b00) begin
            mpos[i] = 1'b0;
            mneg[i] = 1'b0;
         end else begin
            if (msym[i] != 2'b11) lp = ~lp;
            mpos[i] = lp;
            mneg[i] = ~lp;
         end
      end
   endfunction

   initial begin
      bit [1:0] s2c[9];
      bit       s2d[9];
      bit       s2p[9];
      bit [1:0] s3c[10];
      bit       s3d[10];
      bit       s3p[10];
      bit       s3n[10];
      int       strobes;
      int       budget;
      int       last_idx;
      int       bad;
      int       run;
      int       maxrun;
      bit       prevp;
      bit       dec[N];
      bit       have_v;
      bit       v_pol;

      checks     = 0;
      failures   = 0;
      rnd_prints = 0;
      rst        = 1'b1;
      ifc.en     = 1'b0;
      ifc.din    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out("por", 2'b00, 1'b0, 1'b0);

      e1c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3};
      e1p = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
      e1n = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
      s2d = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      s2c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
      s2p = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
      s3d = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      s3c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3};
      s3p = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1};
      s3n = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

      for (int j = 0; j < 12; j++) add_vec(j == 0, 1'b0, e1c[j], e1p[j], e1n[j]);
      for (int j = 0; j < 9; j++)  add_vec(j == 0, s2d[j], s2c[j], s2p[j], 1'b0);
      for (int j = 0; j < 10; j++) add_vec(j == 0, s3d[j], s3c[j], s3p[j], s3n[j]);

      // Directed tables: eight zeros, odd-parity run, even-parity run.
      foreach (tbl[k]) begin
         if (tbl[k].rst_before) do_reset("tbl_rst");
         cyc(1'b1, tbl[k].din);
         check_out($sformatf("tbl%0d", k), tbl[k].code, tbl[k].pos, tbl[k].neg);
      end

      // Zero stream with ~30% strobe duty must match the gapless sequence.
      do_reset("gap_rst");
      strobes  = 0;
      budget   = 0;
      last_idx = -1;
      while (strobes < 12 && budget < 2000) begin
         if ($urandom_range(0, 99) < 30) begin
            cyc(1'b1, 1'b0);
            check_out($sformatf("gap_s%0d", strobes), e1c[strobes], e1p[strobes], e1n[strobes]);
            last_idx = strobes;
            strobes++;
         end else begin
            cyc(1'b0, 1'b0);
            if (last_idx >= 0)
               check_out("gap_hold", e1c[last_idx], e1p[last_idx], e1n[last_idx]);
            else
               check_out("gap_hold0", 2'b00, 1'b0, 1'b0);
         end
         budget++;
      end
      chk("gap_budget", 32'(strobes), 32'd12);

      // Reset in the middle of a run after some marks: no leftover B, polarity restarts.
      do_reset("mid_rst0");
      for (int j = 0; j < 5; j++) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      do_reset("mid_rst");
      for (int j = 0; j < 8; j++) begin
         cyc(1'b1, 1'b0);
         check_out($sformatf("mid_s%0d", j), e1c[j], e1p[j], e1n[j]);
      end

      // Random stream against the reference model; last four data bits forced to 1.
      for (int i = 0; i < NT; i++) rin[i] = ($urandom_range(0, 2) == 0);
      for (int i = N - 4; i < N; i++) rin[i] = 1'b1;
      for (int i = N; i < NT; i++) rin[i] = 1'b0;
      build_model();
      do_reset("rnd_rst");
      for (int k = 0; k < NT; k++) begin
         cyc(1'b1, rin[k]);
         if (k >= 4) begin
            checks++;
            if (ifc.code_out !== msym[k-4] || ifc.pos !== mpos[k-4] || ifc.neg !== mneg[k-4]) begin
               failures++;
               if (rnd_prints < 10)
                  $display("FAIL rnd idx=%0d actual code=%0d pos=%0b neg=%0b expected code=%0d pos=%0b neg=%0b",
                           k - 4, ifc.code_out, ifc.pos, ifc.neg, msym[k-4], mpos[k-4], mneg[k-4]);
               rnd_prints++;
            end
            lpulse[k-4] = ifc.pos | ifc.neg;
            lpol[k-4]   = ifc.pos;
            ocode[k-4]  = ifc.code_out;
         end else begin
            check_out("rnd_fill", 2'b00, 1'b0, 1'b0);
         end
      end

      // Line-level decode: a pulse repeating the previous polarity is V; clear it and the 3 before.
      prevp = 1'b0;
      for (int i = 0; i < N; i++) begin
         dec[i] = lpulse[i];
         if (lpulse[i]) begin
            if (lpol[i] == prevp && i >= 3)
               for (int j = i - 3; j <= i; j++) dec[j] = 1'b0;
            prevp = lpol[i];
         end
      end
      bad = 0;
      for (int i = 0; i < N; i++) if (dec[i] != rin[i]) bad++;
      chk("rnd_decode_errs", 32'(bad), 32'd0);

      run    = 0;
      maxrun = 0;
      for (int i = 0; i < N; i++) begin
         run    = lpulse[i] ? 0 : run + 1;
         maxrun = (run > maxrun) ? run : maxrun;
      end
      chk("rnd_max_zero_run_lt4", 32'(maxrun < 4), 32'd1);

      bad    = 0;
      have_v = 1'b0;
      v_pol  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ocode[i] == 2'b11) begin
            if (have_v && lpol[i] == v_pol) bad++;
            have_v = 1'b1;
            v_pol  = lpol[i];
         end
      end
      chk("rnd_v_alternate_errs", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hdb3_enc_ctrl.md
# hdb3_enc_ctrl

HDB3 encoder controller for the line-coding chain; it is the transmit-side counterpart of the V/B-stripping decoder. It takes a unipolar NRZ bit stream and runs a 4-deep look-ahead pipeline that detects runs of four zeros and decides between `000V` and `B00V` substitution. A polarity scheduler then assigns +/- to every pulse. It emits a marked 2-bit code for loopback into the decoder, plus bipolar line drive signals.

## Interface
Parameters:
- `INIT_POL`, default 1'b0: polarity of the "last pulse" after reset (0 = negative), so the first mark after reset is positive.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: bit strobe. One input bit is consumed and one output symbol is produced per cycle with `en`=1. With `en`=0 all state holds.
- `din` in 1: NRZ data bit, sampled when `en`=1.
- `code_out` out 2: marked symbol, 00 = zero, 01 = one, 10 = B, 11 = V.
- `dec_code` out 2: decoder-compatible symbol, 00 = zero, 01 = one or B, 11 = V.
- `b_flag` out 1: 1 when the current symbol is an inserted B.
- `pos` out 1: positive pulse on the line.
- `neg` out 1: negative pulse on the line. `pos` and `neg` are never both 1.

## Operation
- Reset values:
  - pipeline stages s0..s3 = 00;
  - `zero_cnt` = 0;
  - `par` = 0, meaning an even number of marks since the last V;
  - `last_pol` = `INIT_POL`;
  - all outputs = 0.
- Input side, on each strobe. Stages shift s0→s1→s2→s3, and s3 moves to the output register.
  - `din`=1: s0 ← 01, `zero_cnt` ← 0, `par` toggles.
  - `din`=0 with `zero_cnt` < 3: s0 ← 00, `zero_cnt` increments.
  - `din`=0 with `zero_cnt` = 3 (fourth zero):
    - s0 ← 11 (V) and `zero_cnt` ← 0.
    - If `par`=0: the value entering s3 this cycle (the first zero of the run) is overwritten with 10 (B).
    - If `par`=1: no B is inserted.
    - `par` ← 0 in both cases.
- Run handling:
  - The zero counter saturates only through substitution, so eight zeros produce two independent substitutions.
  - A V is never counted as a zero for the next run.
- Output side, evaluated when s3 moves to the output register:
  - Symbol 00: `pos`=`neg`=0.
  - Symbol 01 or 10: `last_pol` toggles, and the pulse is driven with the new polarity.
  - Symbol 11: the pulse is driven with the current `last_pol` (violation), and `last_pol` is unchanged.
- `dec_code` = {`code_out`==11, `code_out`!=00}. `b_flag` = (`code_out`==10).

## Timing
- Latency: a bit accepted on strobe k appears on the outputs at strobe k+4.
  - The first 4 strobes after reset emit 00.
- Outputs are registered and hold their value between strobes.
- B and V of one substitution are decided in the same cycle. B leaves the pipeline 3 strobes before its V.
- Reset has priority over `en`. A reset in the middle of a run discards the pipeline and any pending B; there is no partial substitution.
- `en` gaps of any length are transparent; the output sequence is identical to gapless operation.

## Structure
- Shared package `hdb3_pkg` holds:
  - code constants `HDB3_ZERO`=2'b00, `HDB3_ONE`=2'b01, `HDB3_B`=2'b10, `HDB3_V`=2'b11;
  - the `dec_code` mapping function.
- The decoder block imports the same package.
- One sub-module, `hdb3_pol_sched`, takes s3, `en`, `clk` and `rst`. It owns `last_pol` and the output registers.
- The top level holds the pipeline, `zero_cnt` and `par`.

## Test plan
1. Reset, then `din`=0 for 8 strobes. Expected outputs from strobe 4: `code_out` = B,0,0,V,B,0,0,V; polarity +,0,0,+,-,0,0,-.
2. Reset, then `din` = 1,0,0,0,0. Expected `code_out` = 01,00,00,00,11 (odd parity, no B); polarity +,0,0,0,+.
3. Reset, then `din` = 1,1,0,0,0,0. Expected `code_out` = 01,01,10,00,00,11; polarity +,-,+,0,0,+.
4. Random 10k-bit stream checked against a reference model and fed through the decoder. Requirements:
   - decoded data equals `din` delayed by the combined latency;
   - no 4 consecutive zero symbols on `pos|neg`;
   - consecutive V pulses always alternate polarity.
5. `din`=0 stream with `en` toggling randomly (duty 30%). The output sequence sampled on strobes is identical to scenario 1.
6. Assert `rst` after 2 zeros of a run, then drive `din`=0 for 4 strobes. All outputs are 0 during and after reset until strobe 4. The new run emits B00V with B polarity +.
